// File: rtl/fifo_alu_sequencer_pkg.sv
// Shared types and constants for the FIFO/ALU sequencer: FSM state encoding,
// ALU opcode values and the default error byte.
package fifo_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  localparam logic [5:0] OPC_ADD = 6'b100000;
  localparam logic [5:0] OPC_SUB = 6'b100010;
  localparam logic [5:0] OPC_AND = 6'b100100;
  localparam logic [5:0] OPC_OR  = 6'b100101;
  localparam logic [5:0] OPC_XOR = 6'b100110;
  localparam logic [5:0] OPC_NOR = 6'b100111;
  localparam logic [5:0] OPC_SRA = 6'b000011;
  localparam logic [5:0] OPC_SRL = 6'b000010;

  localparam logic [7:0] ERR_CODE_DEFAULT = 8'hFF;

  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_NOR, OPC_SRA, OPC_SRL: op_is_valid = 1'b1;
      default:                            op_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_alu_sequencer_if.sv
// Bundle of RX FIFO, TX FIFO and ALU signals between the sequencer (master)
// and its surroundings (slave).
interface fifo_alu_sequencer_if #(
  parameter int B  = 8,
  parameter int OP = 6
);
  logic          rx_empty;
  logic [B-1:0]  rx_data;
  logic          rx_rd;
  logic          tx_full;
  logic          tx_wr;
  logic [B-1:0]  tx_data;
  logic [B-1:0]  a;
  logic [B-1:0]  b;
  logic [OP-1:0] op;
  logic [B-1:0]  alu_result;

  modport master (
    input  rx_empty, rx_data, tx_full, alu_result,
    output rx_rd, tx_wr, tx_data, a, b, op
  );

  modport slave (
    output rx_empty, rx_data, tx_full, alu_result,
    input  rx_rd, tx_wr, tx_data, a, b, op
  );
endinterface

// File: rtl/fifo_alu_sequencer.sv
// Pops A, B, opcode from the RX FIFO, runs them through the ALU and pushes the
// result to the TX FIFO. Optional opcode check: FIFO_ALU_SEQUENCER_OPCHECK_EN.
module fifo_alu_sequencer
  import fifo_alu_sequencer_pkg::*;
#(
  parameter int B  = 8,
  parameter int OP = 6
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
  ,
  parameter logic [B-1:0] ERR_CODE = ERR_CODE_DEFAULT
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fifo_alu_sequencer_if.master bus,
  output logic                 o_busy,
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
  output logic                 o_err,
`endif
  output logic [7:0]           o_txn_cnt
);

  state_t        r_state;
  logic [B-1:0]  r_a;
  logic [B-1:0]  r_b;
  logic [OP-1:0] r_op;
  logic [B-1:0]  r_tx_data;
  logic [7:0]    r_txn_cnt;
  logic          w_in_get;
  logic          w_rx_rd;
  logic          w_tx_wr;
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
  logic          r_op_bad;
  logic          r_err;
`endif

  // Strobes are decoded from the registered state so the FIFO sees them in the
  // same cycle the flag allows; held low while reset is asserted.
  assign w_in_get = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                    (r_state == ST_GET_OP);
  assign w_rx_rd  = !i_reset && w_in_get && !bus.rx_empty;
  assign w_tx_wr  = !i_reset && (r_state == ST_SEND) && !bus.tx_full;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_GET_A;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_tx_data <= '0;
      r_txn_cnt <= '0;
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
      r_op_bad  <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_GET_A: if (w_rx_rd) begin
          r_a     <= bus.rx_data;
          r_state <= ST_GET_B;
        end
        ST_GET_B: if (w_rx_rd) begin
          r_b     <= bus.rx_data;
          r_state <= ST_GET_OP;
        end
        ST_GET_OP: if (w_rx_rd) begin
          r_op    <= bus.rx_data[OP-1:0];
          r_state <= ST_EXEC;
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
          r_op_bad <= !op_is_valid(bus.rx_data[5:0]);
          if (!op_is_valid(bus.rx_data[5:0])) r_err <= 1'b1;
`endif
        end
        ST_EXEC: begin
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
          r_tx_data <= r_op_bad ? ERR_CODE : bus.alu_result;
`else
          r_tx_data <= bus.alu_result;
`endif
          r_state   <= ST_SEND;
        end
        ST_SEND: if (w_tx_wr) begin
          r_txn_cnt <= r_txn_cnt + 8'd1;
          r_state   <= ST_GET_A;
        end
        default: r_state <= ST_GET_A;
      endcase
    end
  end

  assign bus.rx_rd   = w_rx_rd;
  assign bus.tx_wr   = w_tx_wr;
  assign bus.tx_data = r_tx_data;
  assign bus.a       = r_a;
  assign bus.b       = r_b;
  assign bus.op      = r_op;
  assign o_busy      = (r_state != ST_GET_A);
  assign o_txn_cnt   = r_txn_cnt;
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
  assign o_err       = r_err;
`endif

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// Self-checking bench for fifo_alu_sequencer: queue-based FIFO models, a
// stand-in ALU, table vectors, directed corner cases and randomized traffic.
module tb_fifo_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] txn_cnt;
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  fifo_alu_sequencer_if #(.B(8), .OP(6)) bus ();

  fifo_alu_sequencer #(.B(8), .OP(6)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus.master),
    .o_busy    (busy),
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
    .o_err     (err),
`endif
    .o_txn_cnt (txn_cnt)
  );

  // Stand-in ALU; unknown opcodes give a distinctive byte.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      default: return 8'h5A;
    endcase
  endfunction

  always_comb bus.alu_result = alu_f(bus.a, bus.b, bus.op);

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic logic [7:0] model_txn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] opb);
`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) if (valid_ops[i] == opb[5:0]) ok = 1'b1;
    if (!ok) return 8'hFF;
`endif
    return alu_f(a, b, opb[5:0]);
  endfunction

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  int         pop_cyc[$];
  int         push_cyc[$];
  int         cyc = 0;
  int         pops_total = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       rx_hold = 1'b0;
  logic       tx_full_drv = 1'b0;
  logic       s_rd, s_wr;
  logic [7:0] s_txd;

  typedef struct {
    string      nm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic update_rx();
    bus.rx_empty = rx_hold || (rx_q.size() == 0);
    bus.rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    bus.tx_full  = tx_full_drv;
  endtask

  // One clock: sample strobes mid-cycle, then apply the FIFO effects just after the edge.
  task automatic step();
    @(negedge clk);
    s_rd  = bus.rx_rd;
    s_wr  = bus.tx_wr;
    s_txd = bus.tx_data;
    if (s_rd || s_wr) check("rd_wr_exclusive", 32'(s_rd & s_wr), 32'd0);
    if (s_rd) check("rd_while_empty", 32'(bus.rx_empty), 32'd0);
    if (s_wr) check("wr_while_full", 32'(bus.tx_full), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    if (s_rd) begin
      if (rx_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_on_empty: pop seen with empty model FIFO (cycle %0d)", cyc);
      end else begin
        rx_q.delete(0);
        pops_total++;
        pop_cyc.push_back(cyc);
      end
    end
    if (s_wr) begin
      tx_got.push_back(s_txd);
      push_cyc.push_back(cyc);
    end
    update_rx();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(opb);
    update_rx();
  endtask

  task automatic expect_push(input string nm, input logic [7:0] exp);
    int k;
    k = 0;
    while (tx_got.size() == 0 && k < 200) begin
      step();
      k++;
    end
    if (tx_got.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no push within 200 cycles, expected %0h", nm, exp);
    end else begin
      $display("txn %s: pushed %02h expected %02h", nm, tx_got[0], exp);
      check(nm, 32'(tx_got[0]), 32'(exp));
      tx_got.delete(0);
      exp_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_q.delete();
    tx_got.delete();
    update_rx();
    steps(2);
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"},       32'(bus.a),       32'd0);
    check({tag, "_b"},       32'(bus.b),       32'd0);
    check({tag, "_op"},      32'(bus.op),      32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_busy"},    32'(busy),        32'd0);
    check({tag, "_rx_rd"},   32'(bus.rx_rd),   32'd0);
    check({tag, "_tx_wr"},   32'(bus.tx_wr),   32'd0);
    check({tag, "_cnt"},     32'(txn_cnt),     32'd0);
  endtask

  initial begin
    int p0;
    int k;
    logic [7:0] a, b, o, tx_hold_val;
    logic [7:0] exp_q[$];

    tbl[0] = '{"add",      8'h05, 8'h03, 8'h20, 8'h08};
    tbl[1] = '{"add_wrap", 8'hFF, 8'h02, 8'h20, 8'h01};
    tbl[2] = '{"sub",      8'h09, 8'h04, 8'h22, 8'h05};
    tbl[3] = '{"and",      8'h0F, 8'hF0, 8'h24, 8'h00};
    tbl[4] = '{"or",       8'h0F, 8'hF0, 8'h25, 8'hFF};
    tbl[5] = '{"xor",      8'hAA, 8'h0F, 8'h26, 8'hA5};
    tbl[6] = '{"nor",      8'h0F, 8'h30, 8'h27, 8'hC0};
    tbl[7] = '{"sra",      8'h80, 8'h02, 8'h03, 8'hE0};
    tbl[8] = '{"op_hibits",8'h80, 8'h02, 8'hC2, 8'h20};

    update_rx();
    steps(2);
    check_reset_vals("reset");
    rst = 1'b0;

    // Latency: three back-to-back pops, push four cycles after the first pop.
    pop_cyc.delete();
    push_cyc.delete();
    push3(8'h05, 8'h03, 8'h20);
    expect_push("latency_add", 8'h08);
    check("latency_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3 && push_cyc.size() == 1) begin
      check("latency_pop1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("latency_pop2", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);
      check("latency_push", 32'(push_cyc[0] - pop_cyc[0]), 32'd4);
    end
    check("latency_cnt", 32'(txn_cnt), 32'(exp_cnt));

    for (int i = 0; i < 9; i++) begin
      push3(tbl[i].a, tbl[i].b, tbl[i].opb);
      expect_push(tbl[i].nm, tbl[i].exp);
      step();
      check({tbl[i].nm, "_cnt"}, 32'(txn_cnt), 32'(exp_cnt));
      check({tbl[i].nm, "_a"}, 32'(bus.a), 32'(tbl[i].a));
    end

    // Starved RX: stalls in each GET with no extra pops.
    p0 = pops_total;
    rx_q.push_back(8'h0F); update_rx();
    steps(5);
    check("stall_pops1", 32'(pops_total - p0), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    rx_q.push_back(8'hF0); update_rx();
    steps(5);
    check("stall_pops2", 32'(pops_total - p0), 32'd2);
    rx_q.push_back(8'h25); update_rx();
    expect_push("stall_or", 8'hFF);
    push_cyc.delete();
    steps(5);
    check("stall_pops3", 32'(pops_total - p0), 32'd3);
    check("stall_no_extra_push", 32'(push_cyc.size()), 32'd0);

    // TX full for ten cycles once SEND is reached.
    tx_full_drv = 1'b1;
    p0 = pops_total;
    push3(8'h12, 8'h34, 8'h20);
    k = 0;
    while (pops_total - p0 < 3 && k < 50) begin step(); k++; end
    steps(1);
    tx_hold_val = bus.tx_data;
    check("full_captured", 32'(tx_hold_val), 32'h46);
    for (int i = 0; i < 10; i++) begin
      step();
      check("full_no_push", 32'(tx_got.size()), 32'd0);
      check("full_data_stable", 32'(bus.tx_data), 32'(tx_hold_val));
    end
    tx_full_drv = 1'b0;
    update_rx();
    step();
    check("full_push_next", 32'(tx_got.size()), 32'd1);
    expect_push("full_release", 8'h46);

    // Reset after two pops: partial transaction dropped, then a fresh one.
    p0 = pops_total;
    rx_q.push_back(8'h77); rx_q.push_back(8'h11); update_rx();
    k = 0;
    while (pops_total - p0 < 2 && k < 50) begin step(); k++; end
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    step();
    rst = 1'b0;
    exp_cnt = 8'd0;
    steps(3);
    check("midreset_no_push", 32'(tx_got.size()), 32'd0);
    push3(8'h09, 8'h04, 8'h22);
    expect_push("after_reset_sub", 8'h05);
    step();
    check("after_reset_cnt", 32'(txn_cnt), 32'd1);

`ifdef FIFO_ALU_SEQUENCER_OPCHECK_EN
    do_reset();
    check("err_reset", 32'(err), 32'd0);
    push3(8'h11, 8'h22, 8'h3F);
    expect_push("bad_opcode", 8'hFF);
    check("err_set", 32'(err), 32'd1);
    push3(8'h09, 8'h04, 8'h22);
    expect_push("sub_after_err", 8'h05);
    check("err_sticky", 32'(err), 32'd1);
    step();
    check("err_cnt", 32'(txn_cnt), 32'd2);
`else
    push3(8'h11, 8'h22, 8'h3F);
    expect_push("unchecked_op", 8'h5A);
`endif

    // Randomized RX gaps and TX back-pressure against the model.
    do_reset();
    p0 = pops_total;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 9));
      o = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {2'($urandom), valid_ops[$urandom_range(0, 7)]};
      push3(a, b, o);
      exp_q.push_back(model_txn(a, b, o));
    end
    k = 0;
    while (exp_q.size() > 0 && k < 3000) begin
      rx_hold     = ($urandom_range(0, 3) == 0);
      tx_full_drv = ($urandom_range(0, 2) == 0);
      update_rx();
      step();
      k++;
      if (tx_got.size() > 0) begin
        check("rand_result", 32'(tx_got[0]), 32'(exp_q[0]));
        tx_got.delete(0);
        exp_q.delete(0);
      end
    end
    check("rand_left", 32'(exp_q.size()), 32'd0);
    rx_hold = 1'b0;
    tx_full_drv = 1'b0;
    update_rx();
    steps(2);
    check("rand_cnt", 32'(txn_cnt), 32'd40);
    check("rand_pops", 32'(pops_total - p0), 32'd120);

    // 256 back-to-back transactions wrap the counter to zero.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 7));
      o = {2'b00, valid_ops[i % 8]};
      push3(a, b, o);
      exp_q.push_back(model_txn(a, b, o));
    end
    k = 0;
    while (exp_q.size() > 0 && k < 1700) begin
      step();
      k++;
      if (tx_got.size() > 0) begin
        check("wrap_result", 32'(tx_got[0]), 32'(exp_q[0]));
        tx_got.delete(0);
        exp_q.delete(0);
        if (exp_q.size() == 1) begin
          #1;
          check("wrap_cnt_255", 32'(txn_cnt), 32'd255);
        end
      end
    end
    check("wrap_left", 32'(exp_q.size()), 32'd0);
    step();
    check("wrap_cnt_zero", 32'(txn_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
